// File: rtl/dci_baud_ctl_if.sv
// Host/clkgen-facing signal bundle for the DCI baud-rate controller.
// The host side (register interface, shifter, clkgen) is master; the controller is slave.
interface dci_baud_ctl_if;
  logic       rate_wr;
  logic [1:0] rate_sel;
  logic       busy_in;
  logic       clk_gen;
  logic       en_300_n;
  logic       en_600_n;
  logic       en_1200_n;
  logic [1:0] rate_cur;
  logic       ready;
  logic       lock;
  logic       err;

  modport master (
    output rate_wr, rate_sel, busy_in, clk_gen,
    input  en_300_n, en_600_n, en_1200_n, rate_cur, ready, lock, err
  );

  modport slave (
    input  rate_wr, rate_sel, busy_in, clk_gen,
    output en_300_n, en_600_n, en_1200_n, rate_cur, ready, lock, err
  );
endinterface

// File: rtl/dci_baud_ctl.sv
// Baud-rate controller: switches clkgen enables through a quiet gap once the shifter
// is idle, then checks the clkgen output period and reports lock or a sticky error.
module dci_baud_ctl #(
  parameter int QUIET    = 4,
  parameter int PER_300  = 1632,
  parameter int PER_600  = 832,
  parameter int PER_1200 = 416,
  parameter int TOL      = 4,
  parameter int LOCK_CNT = 2,
  parameter int CW       = 12
) (
  input logic          clk_in,
  input logic          rst,
  dci_baud_ctl_if.slave bus
);

  localparam int QW = $clog2(QUIET + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [QW-1:0] QUIET_LOAD = QW'(QUIET - 1);
  localparam logic [CW:0]   TOL_W      = (CW+1)'(TOL);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PEND, ST_QUIET, ST_SYNC, ST_MEAS, ST_RUN
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      tgt_reg, tgt_next;
  logic [1:0]      rate_cur_reg, rate_cur_next;
  logic [2:0]      en_n_reg, en_n_next;
  logic            lock_reg, lock_next;
  logic            err_reg, err_next;
  logic [QW-1:0]   qcnt_reg, qcnt_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [GW-1:0]   good_reg, good_next;
  logic            clk_gen_q;

  logic            rise;
  logic [CW-1:0]   per_sel;
  logic [CW-1:0]   p_meas;
  logic [CW-1:0]   cnt_inc;
  logic signed [CW:0] diff;
  logic [CW:0]     adiff;
  logic [CW:0]     tmo_lim;
  logic            period_ok;
  logic            timeout;
  logic [2:0]      tgt_en_n;

  // Enable bit gi belongs to rate code gi+1 (0: 300, 1: 600, 2: 1200).
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dec
      assign tgt_en_n[gi] = ~(tgt_reg == 2'(gi + 1));
    end
  endgenerate

  always_comb begin
    case (rate_cur_reg)
      2'b01:   per_sel = CW'(PER_300);
      2'b10:   per_sel = CW'(PER_600);
      default: per_sel = CW'(PER_1200);
    endcase
  end

  assign rise      = bus.clk_gen & ~clk_gen_q;
  assign p_meas    = cnt_reg + CW'(1);
  assign cnt_inc   = (&cnt_reg) ? cnt_reg : cnt_reg + CW'(1);
  assign diff      = $signed({1'b0, p_meas}) - $signed({1'b0, per_sel});
  assign adiff     = diff[CW] ? $unsigned(-diff) : $unsigned(diff);
  assign period_ok = (adiff <= TOL_W);
  // Flag the timeout on the edge where the count would reach twice the period.
  assign tmo_lim   = {per_sel, 1'b0} - (CW+1)'(1);
  assign timeout   = ({1'b0, cnt_reg} == tmo_lim);

  always_comb begin
    state_next    = state_reg;
    tgt_next      = tgt_reg;
    rate_cur_next = rate_cur_reg;
    en_n_next     = en_n_reg;
    lock_next     = lock_reg;
    err_next      = err_reg;
    qcnt_next     = qcnt_reg;
    cnt_next      = cnt_reg;
    good_next     = good_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.rate_wr) begin
          tgt_next   = bus.rate_sel;
          err_next   = 1'b0;
          lock_next  = 1'b0;
          state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!bus.busy_in) begin
          en_n_next  = 3'b111;
          qcnt_next  = QUIET_LOAD;
          state_next = ST_QUIET;
        end
      end
      ST_QUIET: begin
        if (qcnt_reg == '0) begin
          rate_cur_next = tgt_reg;
          if (tgt_reg == 2'b00) begin
            state_next = ST_IDLE;
          end else begin
            en_n_next  = tgt_en_n;
            cnt_next   = '0;
            state_next = ST_SYNC;
          end
        end else begin
          qcnt_next = qcnt_reg - QW'(1);
        end
      end
      ST_SYNC: begin
        cnt_next = cnt_inc;
        if (rise) begin
          cnt_next   = '0;
          good_next  = '0;
          state_next = ST_MEAS;
        end else if (timeout) begin
          err_next  = 1'b1;
          lock_next = 1'b0;
          cnt_next  = '0;
        end
      end
      ST_MEAS, ST_RUN: begin
        if (state_reg == ST_RUN && bus.rate_wr) begin
          tgt_next   = bus.rate_sel;
          err_next   = 1'b0;
          lock_next  = 1'b0;
          state_next = ST_PEND;
        end else begin
          cnt_next = cnt_inc;
          if (rise) begin
            cnt_next = '0;
            if (period_ok) begin
              if (state_reg == ST_MEAS) begin
                good_next = good_reg + GW'(1);
                if (good_reg + GW'(1) == GW'(LOCK_CNT)) begin
                  lock_next  = 1'b1;
                  state_next = ST_RUN;
                end
              end
            end else begin
              err_next   = 1'b1;
              lock_next  = 1'b0;
              good_next  = '0;
              state_next = ST_MEAS;
            end
          end else if (timeout) begin
            err_next   = 1'b1;
            lock_next  = 1'b0;
            cnt_next   = '0;
            state_next = ST_SYNC;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      tgt_reg      <= 2'b00;
      rate_cur_reg <= 2'b00;
      en_n_reg     <= 3'b111;
      lock_reg     <= 1'b0;
      err_reg      <= 1'b0;
      qcnt_reg     <= '0;
      cnt_reg      <= '0;
      good_reg     <= '0;
      clk_gen_q    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tgt_reg      <= tgt_next;
      rate_cur_reg <= rate_cur_next;
      en_n_reg     <= en_n_next;
      lock_reg     <= lock_next;
      err_reg      <= err_next;
      qcnt_reg     <= qcnt_next;
      cnt_reg      <= cnt_next;
      good_reg     <= good_next;
      clk_gen_q    <= bus.clk_gen;
    end
  end

  assign bus.en_300_n  = en_n_reg[0];
  assign bus.en_600_n  = en_n_reg[1];
  assign bus.en_1200_n = en_n_reg[2];
  assign bus.rate_cur  = rate_cur_reg;
  assign bus.ready     = (state_reg == ST_IDLE) || (state_reg == ST_RUN);
  assign bus.lock      = lock_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_dci_baud_ctl.sv
// Directed bench for dci_baud_ctl: a clkgen model with programmable period drives
// clk_gen; each scenario task checks enables, rate, ready, lock and err at fixed cycles.
module tb_dci_baud_ctl;
  logic clk_in = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   gen_per = 0;
  int   gcnt    = 0;
  logic [2:0] en_vec;

  dci_baud_ctl_if bus ();

  dci_baud_ctl dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  assign en_vec = {bus.en_1200_n, bus.en_600_n, bus.en_300_n};

  // Advance to the next falling edge and step the clkgen model (rise every gen_per cycles).
  task automatic tick();
    @(negedge clk_in);
    if (gen_per == 0) begin
      gcnt = 0;
      bus.clk_gen = 1'b0;
    end else begin
      gcnt = (gcnt + 1 >= gen_per) ? 0 : gcnt + 1;
      bus.clk_gen = (gcnt < gen_per / 2);
    end
  endtask

  // Restart the model so that its first rise is seen two edges later.
  task automatic set_gen(input int per);
    gen_per = per;
    gcnt = per - 1;
    bus.clk_gen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rate_wr = 1'b0;
    bus.rate_sel = 2'b00;
    bus.busy_in = 1'b0;
    bus.clk_gen = 1'b0;
    gen_per = 0;
    tick();
    tick();
    total++; if (en_vec !== 3'b111) begin bad++; $display("FAIL reset_en: got %b want 111", en_vec); end
    total++; if (bus.rate_cur !== 2'b00) begin bad++; $display("FAIL reset_rate: got %b want 00", bus.rate_cur); end
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
    total++; if (bus.lock !== 1'b0) begin bad++; $display("FAIL reset_lock: got %b want 0", bus.lock); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    rst = 1'b0;
    tick();
    $display("reset: en=%b rate=%b ready=%b", en_vec, bus.rate_cur, bus.ready);
  endtask

  task automatic test_basic_1200();
    int viol = 0;
    bus.rate_sel = 2'b11;
    bus.rate_wr = 1'b1;
    tick();
    bus.rate_wr = 1'b0;
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL basic_ready_pend: got %b want 0", bus.ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (en_vec !== 3'b111) begin bad++; $display("FAIL basic_quiet[%0d]: got %b want 111", i, en_vec); end
    end
    tick();
    total++; if (en_vec !== 3'b011) begin bad++; $display("FAIL basic_en: got %b want 011", en_vec); end
    total++; if (bus.rate_cur !== 2'b11) begin bad++; $display("FAIL basic_rate: got %b want 11", bus.rate_cur); end
    set_gen(416);
    for (int i = 0; i < 833; i++) begin
      tick();
      if ($countones(~en_vec) > 1) viol++;
    end
    total++; if (bus.lock !== 1'b0) begin bad++; $display("FAIL basic_early_lock: got %b want 0", bus.lock); end
    tick();
    total++; if (bus.lock !== 1'b1) begin bad++; $display("FAIL basic_lock: got %b want 1", bus.lock); end
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL basic_ready: got %b want 1", bus.ready); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", bus.err); end
    total++; if (viol !== 0) begin bad++; $display("FAIL basic_one_hot: got %0d violations want 0", viol); end
    $display("basic_1200: lock=%b ready=%b err=%b", bus.lock, bus.ready, bus.err);
  endtask

  task automatic test_busy_defer();
    int held_bad = 0;
    int viol = 0;
    bus.busy_in = 1'b1;
    bus.rate_sel = 2'b01;
    bus.rate_wr = 1'b1;
    tick();
    bus.rate_wr = 1'b0;
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL busy_ready: got %b want 0", bus.ready); end
    total++; if (bus.lock !== 1'b0) begin bad++; $display("FAIL busy_lock_clr: got %b want 0", bus.lock); end
    for (int i = 0; i < 499; i++) begin
      if (en_vec !== 3'b011) held_bad++;
      tick();
    end
    total++; if (held_bad !== 0 || en_vec !== 3'b011) begin bad++; $display("FAIL busy_hold: got %0d bad cycles, en=%b want 0, 011", held_bad, en_vec); end
    bus.busy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (en_vec !== 3'b111) begin bad++; $display("FAIL busy_quiet[%0d]: got %b want 111", i, en_vec); end
    end
    tick();
    total++; if (en_vec !== 3'b110) begin bad++; $display("FAIL busy_en300: got %b want 110", en_vec); end
    total++; if (bus.rate_cur !== 2'b01) begin bad++; $display("FAIL busy_rate: got %b want 01", bus.rate_cur); end
    set_gen(1632);
    for (int i = 0; i < 3265; i++) begin
      tick();
      if ($countones(~en_vec) > 1) viol++;
    end
    total++; if (bus.lock !== 1'b0) begin bad++; $display("FAIL lock300_early: got %b want 0", bus.lock); end
    tick();
    total++; if (bus.lock !== 1'b1) begin bad++; $display("FAIL lock300: got %b want 1", bus.lock); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL lock300_err: got %b want 0", bus.err); end
    total++; if (viol !== 0) begin bad++; $display("FAIL busy_one_hot: got %0d violations want 0", viol); end
    $display("busy_defer: en=%b rate=%b lock=%b", en_vec, bus.rate_cur, bus.lock);
  endtask

  task automatic test_tolerance();
    bus.rate_sel = 2'b11;
    bus.rate_wr = 1'b1;
    tick();
    bus.rate_wr = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++; if (en_vec !== 3'b011) begin bad++; $display("FAIL tol_en: got %b want 011", en_vec); end
    set_gen(420);
    for (int i = 0; i < 841; i++) tick();
    total++; if (bus.lock !== 1'b0) begin bad++; $display("FAIL tol420_early: got %b want 0", bus.lock); end
    tick();
    total++; if (bus.lock !== 1'b1) begin bad++; $display("FAIL tol420_lock: got %b want 1", bus.lock); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL tol420_err: got %b want 0", bus.err); end
    gen_per = 421;
    for (int i = 0; i < 420; i++) tick();
    total++; if (bus.lock !== 1'b1 || bus.err !== 1'b0) begin bad++; $display("FAIL tol421_pre: got lock=%b err=%b want 1 0", bus.lock, bus.err); end
    tick();
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL tol421_err: got %b want 1", bus.err); end
    total++; if (bus.lock !== 1'b0) begin bad++; $display("FAIL tol421_lock: got %b want 0", bus.lock); end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL tol421_ready: got %b want 0", bus.ready); end
    gen_per = 420;
    for (int i = 0; i < 839; i++) tick();
    total++; if (bus.lock !== 1'b0) begin bad++; $display("FAIL relock_early: got %b want 0", bus.lock); end
    tick();
    total++; if (bus.lock !== 1'b1) begin bad++; $display("FAIL relock: got %b want 1", bus.lock); end
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", bus.err); end
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL relock_ready: got %b want 1", bus.ready); end
    $display("tolerance: lock=%b err=%b", bus.lock, bus.err);
  endtask

  task automatic test_off_ignore();
    bus.rate_sel = 2'b00;
    bus.rate_wr = 1'b1;
    tick();
    bus.rate_wr = 1'b0;
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL off_err_clr: got %b want 0", bus.err); end
    total++; if (bus.lock !== 1'b0) begin bad++; $display("FAIL off_lock_clr: got %b want 0", bus.lock); end
    tick();
    total++; if (en_vec !== 3'b111) begin bad++; $display("FAIL off_quiet_en: got %b want 111", en_vec); end
    tick();
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL off_quiet_ready: got %b want 0", bus.ready); end
    bus.rate_sel = 2'b11;
    bus.rate_wr = 1'b1;
    tick();
    bus.rate_wr = 1'b0;
    bus.rate_sel = 2'b00;
    tick();
    tick();
    total++; if (en_vec !== 3'b111) begin bad++; $display("FAIL off_en: got %b want 111", en_vec); end
    total++; if (bus.rate_cur !== 2'b00) begin bad++; $display("FAIL off_rate: got %b want 00", bus.rate_cur); end
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL off_ready: got %b want 1", bus.ready); end
    total++; if (bus.lock !== 1'b0) begin bad++; $display("FAIL off_lock: got %b want 0", bus.lock); end
    for (int i = 0; i < 8; i++) tick();
    total++; if (en_vec !== 3'b111 || bus.ready !== 1'b1) begin bad++; $display("FAIL off_ignore: got en=%b ready=%b want 111 1", en_vec, bus.ready); end
    $display("off_ignore: en=%b rate=%b ready=%b", en_vec, bus.rate_cur, bus.ready);
  endtask

  task automatic test_timeout();
    set_gen(0);
    bus.rate_sel = 2'b10;
    bus.rate_wr = 1'b1;
    tick();
    bus.rate_wr = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++; if (en_vec !== 3'b101) begin bad++; $display("FAIL tmo_en: got %b want 101", en_vec); end
    total++; if (bus.rate_cur !== 2'b10) begin bad++; $display("FAIL tmo_rate: got %b want 10", bus.rate_cur); end
    for (int i = 0; i < 1663; i++) tick();
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL tmo_early: got %b want 0", bus.err); end
    tick();
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", bus.err); end
    total++; if (bus.lock !== 1'b0 || bus.ready !== 1'b0) begin bad++; $display("FAIL tmo_state: got lock=%b ready=%b want 0 0", bus.lock, bus.ready); end
    $display("timeout: err=%b ready=%b", bus.err, bus.ready);
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    total++; if (en_vec !== 3'b111) begin bad++; $display("FAIL rstmid_en: got %b want 111", en_vec); end
    total++; if (bus.rate_cur !== 2'b00) begin bad++; $display("FAIL rstmid_rate: got %b want 00", bus.rate_cur); end
    total++; if (bus.err !== 1'b0 || bus.ready !== 1'b1) begin bad++; $display("FAIL rstmid_flags: got err=%b ready=%b want 0 1", bus.err, bus.ready); end
    rst = 1'b0;
    tick();
    $display("reset_mid: en=%b err=%b ready=%b", en_vec, bus.err, bus.ready);
  endtask

  initial begin
    test_reset();
    test_basic_1200();
    test_busy_defer();
    test_tolerance();
    test_off_ignore();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
